// File: rtl/vga_layer_pkg.sv
// Shared encodings and constants for the layer fetch scheduler.
// State names mirror the slot phases: idle, three layer reads, result.
package vga_layer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_T,
      RD_I,
      RD_M,
      RES
   } state_t;

   localparam int L_TITLE = 2;
   localparam int L_ICON  = 1;
   localparam int L_MAP   = 0;

   localparam logic [11:0] COLOR_TRANSPARENT = 12'h000;
   localparam int          RD_LATENCY        = 1;

endpackage

// File: rtl/layer_prio_mux.sv
// Combinational priority select of three layer colours: title > icon > map.
// A transparent colour falls through to the next lower layer.
module layer_prio_mux #(
   parameter int COLOR_W = 12
) (
   input  logic [COLOR_W-1:0] title,
   input  logic [COLOR_W-1:0] icon,
   input  logic [COLOR_W-1:0] map,
   output logic [COLOR_W-1:0] color
);
   import vga_layer_pkg::*;

   localparam logic [COLOR_W-1:0] TRANSP = COLOR_W'(COLOR_TRANSPARENT);

   always_comb begin
      color = map;
      if (title != TRANSP) begin
         color = title;
      end else if (icon != TRANSP) begin
         color = icon;
      end
   end

endmodule

// File: rtl/layer_fetch_scheduler.sv
// Shares one 1-cycle-latency layer memory between title, icon and map per pixel slot.
// Optional sticky overrun output when LFS_OVERRUN_FLAG_EN is defined.
module layer_fetch_scheduler #(
   parameter int ADDR_W      = 14,
   parameter int COLOR_W     = 12,
   parameter int SLOT_CYCLES = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               pix_tick,
   input  logic               video_on,
   input  logic [2:0]         layer_en,
   input  logic [ADDR_W-1:0]  title_addr,
   input  logic [ADDR_W-1:0]  icon_addr,
   input  logic [ADDR_W-1:0]  map_addr,
   output logic               mem_en,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [COLOR_W-1:0] mem_rdata,
   output logic [COLOR_W-1:0] color_out,
   output logic               color_valid,
`ifdef LFS_OVERRUN_FLAG_EN
   output logic               overrun,
`endif
   output logic               busy
);
   import vga_layer_pkg::*;

   if (SLOT_CYCLES < 4 || RD_LATENCY != 1) begin : g_cfg_check
      $error("layer_fetch_scheduler: slot must be >= 4 clocks with 1-cycle memory");
   end

   state_t              state_reg, state_next;
   logic                vid_reg;
   logic [2:0]          en_reg;
   logic [ADDR_W-1:0]   t_addr_reg, i_addr_reg, m_addr_reg, addr_hold_reg;
   logic [COLOR_W-1:0]  title_data_reg, icon_data_reg, color_out_reg;
   logic                icon_rd_reg, map_rd_reg;
   logic                color_valid_reg, busy_reg;
   logic                accept, title_rd, rdata_hit;
   logic [COLOR_W-1:0]  map_data, mux_color;

   assign accept    = pix_tick && (state_reg == IDLE || state_reg == RES);
   assign title_rd  = vid_reg & en_reg[L_TITLE];
   assign rdata_hit = (mem_rdata != '0);
   assign map_data  = map_rd_reg ? mem_rdata : '0;

   // The hit decision for the previous layer is taken from mem_rdata in the same
   // cycle the next read is issued; that is what keeps a full slot at 4 clocks.
   always_comb begin
      state_next = state_reg;
      mem_en     = 1'b0;
      mem_addr   = addr_hold_reg;
      case (state_reg)
         IDLE: begin
            if (pix_tick) state_next = RD_T;
         end
         RD_T: begin
            mem_en     = title_rd;
            state_next = RD_I;
            if (mem_en) mem_addr = t_addr_reg;
         end
         RD_I: begin
            mem_en     = vid_reg & en_reg[L_ICON] & ~(title_rd & rdata_hit);
            state_next = RD_M;
            if (mem_en) mem_addr = i_addr_reg;
         end
         RD_M: begin
            mem_en     = vid_reg & en_reg[L_MAP] & (title_data_reg == '0)
                         & ~(icon_rd_reg & rdata_hit);
            state_next = RES;
            if (mem_en) mem_addr = m_addr_reg;
         end
         RES: begin
            state_next = pix_tick ? RD_T : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   layer_prio_mux #(.COLOR_W(COLOR_W)) u_prio_mux (
      .title (title_data_reg),
      .icon  (icon_data_reg),
      .map   (map_data),
      .color (mux_color)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vid_reg         <= 1'b0;
         en_reg          <= '0;
         t_addr_reg      <= '0;
         i_addr_reg      <= '0;
         m_addr_reg      <= '0;
         addr_hold_reg   <= '0;
         title_data_reg  <= '0;
         icon_data_reg   <= '0;
         icon_rd_reg     <= 1'b0;
         map_rd_reg      <= 1'b0;
         color_out_reg   <= '0;
         color_valid_reg <= 1'b0;
         busy_reg        <= 1'b0;
      end else begin
         addr_hold_reg   <= mem_addr;
         color_valid_reg <= 1'b0;
         busy_reg        <= (state_next == RD_T) || (state_next == RD_I) ||
                            (state_next == RD_M);
         if (accept) begin
            vid_reg    <= video_on;
            en_reg     <= layer_en;
            t_addr_reg <= title_addr;
            i_addr_reg <= icon_addr;
            m_addr_reg <= map_addr;
         end
         // Data is only kept for reads actually issued; otherwise the layer is transparent.
         case (state_reg)
            RD_I: begin
               title_data_reg <= title_rd ? mem_rdata : '0;
               icon_rd_reg    <= mem_en;
            end
            RD_M: begin
               icon_data_reg <= icon_rd_reg ? mem_rdata : '0;
               map_rd_reg    <= mem_en;
            end
            RES: begin
               color_out_reg   <= mux_color;
               color_valid_reg <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef LFS_OVERRUN_FLAG_EN
   logic overrun_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overrun_reg <= 1'b0;
      end else if (pix_tick && busy_reg) begin
         overrun_reg <= 1'b1;
      end
   end

   assign overrun = overrun_reg;
`endif

   assign color_out   = color_out_reg;
   assign color_valid = color_valid_reg;
   assign busy        = busy_reg;

endmodule
